// File: rtl/game_pkg.sv
// Shared definitions for the game board controller: board geometry, cell
// codes, controller state encoding and the packed-board index helper.
package game_pkg;

    localparam int BOARD_DIM  = 5;
    localparam int CELL_W     = 2;
    localparam int BOARD_BITS = BOARD_DIM * BOARD_DIM * CELL_W;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } game_state_t;

    // Bit offset of cell (r,c) inside the packed board; only meaningful for
    // in-range coordinates.
    function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
        return 6'(r) * 6'd10 + 6'(c) * 6'd2;
    endfunction

endpackage

// File: rtl/game_board_ctrl.sv
// 5x5 game board and turn controller. Accepts moves over a valid/ready
// handshake, rejects illegal ones, and samples the external win evaluator
// one cycle after each legal move to declare a win, a draw or a turn change.
// Optional feature: define GAME_UNDO_EN for a one-deep undo of the last move.
module game_board_ctrl
    import game_pkg::*;
#(
    parameter int BOARD_DIM = 5,
    parameter int CELL_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  new_game,
    input  logic                  move_valid,
    output logic                  move_ready,
    input  logic [2:0]            move_row,
    input  logic [2:0]            move_col,
    input  logic                  undo,
    output logic [BOARD_BITS-1:0] board_bit,
    output logic [1:0]            player_id,
    input  logic                  player_won,
    output logic                  move_reject,
    output logic [4:0]            move_count,
    output logic                  game_over,
    output logic [1:0]            winner,
    output logic                  draw
);

    game_state_t           state, state_next;
    logic [BOARD_BITS-1:0] board_next;
    logic [1:0]            player_next;
    logic [4:0]            count_next;
    logic                  reject_next;
    logic [1:0]            winner_next;
    logic                  draw_next;
    logic                  in_range;
    logic                  legal;
    logic [5:0]            move_idx;

`ifdef GAME_UNDO_EN
    logic       undo_vld, undo_vld_next;
    logic [2:0] last_row, last_row_next;
    logic [2:0] last_col, last_col_next;
    logic [5:0] undo_idx;
`else
    logic unused_undo;
    assign unused_undo = undo;
`endif

    assign move_ready = (state == IDLE);
    assign game_over  = (state == DONE);

    // Next-state and next-value logic for the whole controller.
    always_comb begin
        // NOTE: every target gets a hold value first so no path infers a latch.
        state_next  = state;
        board_next  = board_bit;
        player_next = player_id;
        count_next  = move_count;
        reject_next = 1'b0;
        winner_next = winner;
        draw_next   = draw;
`ifdef GAME_UNDO_EN
        undo_vld_next = undo_vld;
        last_row_next = last_row;
        last_col_next = last_col;
        undo_idx      = cell_idx(last_row, last_col);
`endif
        in_range = (int'(move_row) < BOARD_DIM) && (int'(move_col) < BOARD_DIM);
        move_idx = in_range ? cell_idx(move_row, move_col) : 6'd0;
        legal    = in_range && (board_bit[move_idx +: CELL_W] == CELL_EMPTY);

        if (new_game) begin
            state_next  = IDLE;
            board_next  = '0;
            player_next = CELL_P1;
            count_next  = 5'd0;
            winner_next = CELL_EMPTY;
            draw_next   = 1'b0;
`ifdef GAME_UNDO_EN
            undo_vld_next = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (move_valid) begin
                        if (legal) begin
                            board_next[move_idx +: CELL_W] = player_id;
                            count_next = move_count + 5'd1;
                            state_next = CHECK;
`ifdef GAME_UNDO_EN
                            last_row_next = move_row;
                            last_col_next = move_col;
                            undo_vld_next = 1'b0;
`endif
                        end else begin
                            reject_next = 1'b1;
                        end
                    end
`ifdef GAME_UNDO_EN
                    // A simultaneous move takes precedence; undo is dropped.
                    else if (undo && undo_vld) begin
                        board_next[undo_idx +: CELL_W] = CELL_EMPTY;
                        count_next    = move_count - 5'd1;
                        player_next   = player_id ^ 2'b11;
                        undo_vld_next = 1'b0;
                    end
`endif
                end
                CHECK: begin
                    // player_id still names the mover while the evaluator settles.
                    if (player_won) begin
                        state_next  = DONE;
                        winner_next = player_id;
                    end else if (int'(move_count) == BOARD_DIM * BOARD_DIM) begin
                        state_next = DONE;
                        draw_next  = 1'b1;
                    end else begin
                        player_next = player_id ^ 2'b11;
                        state_next  = IDLE;
`ifdef GAME_UNDO_EN
                        undo_vld_next = 1'b1;
`endif
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the board is plain flops and is cleared by reset, since an
        // asynchronous reset must also discard any partly played game.
        if (!rst_n) begin
            state       <= IDLE;
            board_bit   <= '0;
            player_id   <= CELL_P1;
            move_count  <= 5'd0;
            move_reject <= 1'b0;
            winner      <= CELL_EMPTY;
            draw        <= 1'b0;
`ifdef GAME_UNDO_EN
            undo_vld    <= 1'b0;
            last_row    <= 3'd0;
            last_col    <= 3'd0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state       <= state_next;
            board_bit   <= board_next;
            player_id   <= player_next;
            move_count  <= count_next;
            move_reject <= reject_next;
            winner      <= winner_next;
            draw        <= draw_next;
`ifdef GAME_UNDO_EN
            undo_vld    <= undo_vld_next;
            last_row    <= last_row_next;
            last_col    <= last_col_next;
`endif
        end
    end

endmodule

// File: tb/tb_game_board_ctrl.sv
// Scoreboard bench for game_board_ctrl: the driver updates a board-level game
// model and queues the expected observable state; a monitor pops and compares
// whenever the DUT shows a response (reject pulse, CHECK cycle, CHECK result,
// or a driver-requested probe after an action with no visible response).
`timescale 1ns/1ps
module tb_game_board_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic        undo = 1'b0;
    logic        player_won = 1'b0;
    logic [2:0]  move_row = 3'd0;
    logic [2:0]  move_col = 3'd0;
    logic        move_ready;
    logic        move_reject;
    logic        game_over;
    logic        draw;
    logic [49:0] board_bit;
    logic [1:0]  player_id;
    logic [1:0]  winner;
    logic [4:0]  move_count;

    game_board_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .new_game    (new_game),
        .move_valid  (move_valid),
        .move_ready  (move_ready),
        .move_row    (move_row),
        .move_col    (move_col),
        .undo        (undo),
        .board_bit   (board_bit),
        .player_id   (player_id),
        .player_won  (player_won),
        .move_reject (move_reject),
        .move_count  (move_count),
        .game_over   (game_over),
        .winner      (winner),
        .draw        (draw)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [49:0] board;
        logic [1:0]  player;
        logic [4:0]  count;
        logic        ready;
        logic        reject;
        logic        over;
        logic [1:0]  win_id;
        logic        drw;
    } obs_t;

    obs_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    probe = 1'b0;
    bit    was_check = 1'b0;

    // Game model: board as a 2-D array of cell codes plus turn bookkeeping.
    logic [1:0] bd[5][5];
    logic [1:0] m_player;
    int         m_count;
    bit         m_done;
    logic [1:0] m_winner;
    bit         m_draw;
    int         u_r, u_c;
    bit         u_vld;

    task automatic check(input string name, input logic [62:0] act, input logic [62:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                bd[r][c] = 2'b00;
        m_player = 2'b01;
        m_count  = 0;
        m_done   = 1'b0;
        m_winner = 2'b00;
        m_draw   = 1'b0;
        u_vld    = 1'b0;
    endfunction

    function automatic obs_t snap();
        obs_t        o;
        logic [49:0] b;
        b = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                b[r*10 + c*2 +: 2] = bd[r][c];
        o.board  = b;
        o.player = m_player;
        o.count  = 5'(m_count);
        o.ready  = !m_done;
        o.reject = 1'b0;
        o.over   = m_done;
        o.win_id = m_winner;
        o.drw    = m_draw;
        return o;
    endfunction

    function automatic void push(input string tag, input obs_t o);
        exp_q.push_back(o);
        tag_q.push_back(tag);
    endfunction

    // Monitor: compares on every cycle where the DUT presents a response.
    always @(negedge clk) begin
        bit   cur_check;
        bit   ev;
        obs_t act;
        cur_check = rst_n && !move_ready && !game_over;
        ev = rst_n && (move_reject || cur_check || was_check || probe);
        was_check <= cur_check;
        if (ev) begin
            act = {board_bit, player_id, move_count, move_ready, move_reject,
                   game_over, winner, draw};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got %h expected nothing", act);
            end else begin
                check(tag_q.pop_front(), act, exp_q.pop_front());
            end
        end
    end

    // All driver tasks start and end on a falling edge.
    task automatic probe_push(input string tag);
        push(tag, snap());
        @(posedge clk);
        probe = 1'b1;
        @(posedge clk);
        probe = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_move(input int r, input int c, input bit win);
        bit   legal;
        obs_t o;
        move_row   = 3'(r);
        move_col   = 3'(c);
        move_valid = 1'b1;
        if (m_done) begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            move_valid = 1'b0;
            probe_push("ignored_in_done");
            return;
        end
        legal = (r < 5) && (c < 5);
        if (legal) legal = (bd[r][c] == 2'b00);
        if (!legal) begin
            o = snap();
            o.reject = 1'b1;
            push("reject", o);
            @(posedge clk);
            @(negedge clk);
            move_valid = 1'b0;
            return;
        end
        bd[r][c] = m_player;
        m_count++;
        u_vld = 1'b0;
        o = snap();
        o.ready = 1'b0;
        o.over  = 1'b0;
        push("check_cycle", o);
        if (win) begin
            m_done   = 1'b1;
            m_winner = m_player;
        end else if (m_count == 25) begin
            m_done = 1'b1;
            m_draw = 1'b1;
        end else begin
            m_player = m_player ^ 2'b11;
`ifdef GAME_UNDO_EN
            u_vld = 1'b1;
`endif
        end
        u_r = r;
        u_c = c;
        push(win ? "win_result" : "move_result", snap());
        @(posedge clk);
        @(negedge clk);
        move_valid = 1'b0;
        player_won = win;
        @(posedge clk);
        @(negedge clk);
        player_won = 1'b0;
    endtask

    task automatic do_undo();
        undo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        undo = 1'b0;
`ifdef GAME_UNDO_EN
        if (!m_done && u_vld) begin
            bd[u_r][u_c] = 2'b00;
            m_count--;
            m_player = m_player ^ 2'b11;
            u_vld = 1'b0;
        end
`endif
        probe_push("undo");
    endtask

    task automatic do_new_game(input bit with_move);
        new_game   = 1'b1;
        move_valid = with_move;
        move_row   = 3'd1;
        move_col   = 3'd1;
        @(posedge clk);
        @(negedge clk);
        new_game   = 1'b0;
        move_valid = 1'b0;
        model_reset();
        probe_push("new_game");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        probe_push("reset_state");

        // First move, then back-to-back illegal moves.
        do_move(0, 0, 1'b0);
        do_move(0, 0, 1'b0);
        do_move(5, 1, 1'b0);

        // P1 completes row 2 cells 0..3; the evaluator stub reports a win.
        do_new_game(1'b0);
        do_move(2, 0, 1'b0);
        do_move(4, 4, 1'b0);
        do_move(2, 1, 1'b0);
        do_move(4, 3, 1'b0);
        do_move(2, 2, 1'b0);
        do_move(4, 2, 1'b0);
        do_move(2, 3, 1'b1);
        do_move(1, 1, 1'b0);

        // new_game beats a simultaneous move request.
        do_new_game(1'b1);

        // Full board with no win ends in a draw.
        for (int i = 0; i < 25; i++)
            do_move(i / 5, i % 5, 1'b0);
        do_move(0, 0, 1'b0);

        // Undo after a single move, then a second undo with nothing stored.
        do_new_game(1'b0);
        do_move(3, 4, 1'b0);
        do_undo();
        do_undo();

        // Random games with occasional illegal moves, undos and wins.
        for (int g = 0; g < 30; g++) begin
            do_new_game(1'($urandom_range(0, 1)));
            for (int s = 0; s < 80 && !m_done; s++) begin
                if ($urandom_range(0, 9) == 0)
                    do_undo();
                else
                    do_move($urandom_range(0, 5), $urandom_range(0, 5),
                            1'($urandom_range(0, 15) == 0));
            end
            if (m_done)
                do_move($urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drain", 63'(exp_q.size()), 63'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
